// File: rtl/imem_loader.sv
// Serial boot loader: receives a counted, checksummed byte stream and
// writes it as 32-bit words into instruction memory, holding the core in reset.
module imem_loader #(
  parameter int IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam logic [IW-1:0] W_ONE = 1;
  localparam logic [31:0] MAX_N = 32'(IMEM_WORDS);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERROR
  } state_t;

  state_t state, state_nx;

  logic [15:0]   n_words;
  logic [IW-1:0] word_idx;
  logic [1:0]    byte_idx;
  logic [7:0]    csum;
  logic [23:0]   wbuf;

  logic        accept;
  logic [15:0] hdr_n;
  logic        oversize;
  logic        last_word;
  logic        go;

  assign rx_ready  = (state == HDR0) || (state == HDR1) ||
                     (state == DATA) || (state == CSUM);
  assign busy      = rx_ready;
  assign done      = (state == DONE);
  assign error     = (state == ERROR);
  assign cpu_reset = (state != DONE);

  assign accept    = rx_valid && rx_ready;
  assign go        = start && !busy;
  assign hdr_n     = {rx_data, n_words[7:0]};
  assign oversize  = {16'h0, hdr_n} > MAX_N;
  assign last_word = (17'(word_idx) + 17'd1) == {1'b0, n_words};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE, ERROR:
        if (start) state_nx = HDR0;
      HDR0:
        if (accept) state_nx = HDR1;
      HDR1:
        if (accept) begin
          if (oversize)          state_nx = ERROR;
          else if (hdr_n == '0)  state_nx = CSUM;
          else                   state_nx = DATA;
        end
      DATA:
        if (accept && byte_idx == 2'd3 && last_word)
          state_nx = CSUM;
      CSUM:
        if (accept)
          state_nx = (rx_data == csum) ? DONE : ERROR;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_words    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      wbuf       <= '0;
      err_code   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (go) begin
        word_idx <= '0;
        byte_idx <= '0;
        csum     <= '0;
        err_code <= '0;
      end
      if (accept) begin
        unique case (state)
          HDR0: n_words <= {8'h00, rx_data};
          HDR1: begin
            n_words[15:8] <= rx_data;
            if (oversize) err_code <= 2'd1;
          end
          DATA: begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= 32'({word_idx, 2'b00});
              imem_wdata <= {rx_data, wbuf};
              word_idx   <= word_idx + W_ONE;
            end else begin
              wbuf[8*byte_idx +: 8] <= rx_data;
            end
          end
          CSUM:
            if (rx_data != csum) err_code <= 2'd2;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are
// driven, popped as the DUT strobes imem_we.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  stream[$];
  logic [6:0]  st;

  imem_loader #(.IMEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  assign st = {rx_ready, busy, done, error, cpu_reset, err_code};

  always @(negedge clk) begin
    if (imem_we) begin
      logic [63:0] e;
      n_wr++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL write_unexpected: got addr=%h data=%h, want none",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          n_bad++;
          $display("FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                   imem_addr, imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Build header + little-endian words + XOR checksum; queue expected writes.
  task automatic build(input logic [31:0] w[], input logic [7:0] cx);
    logic [7:0] c;
    c = 8'h00;
    stream.delete();
    stream.push_back(8'(w.size()));
    stream.push_back(8'(w.size() >> 8));
    foreach (w[i]) begin
      for (int b = 0; b < 4; b++) begin
        stream.push_back(w[i][8*b +: 8]);
        c ^= w[i][8*b +: 8];
      end
      exp_q.push_back({32'(i * 4), w[i]});
    end
    stream.push_back(c ^ cx);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready_timeout: got 0, want 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_st(input string nm, input logic [6:0] want);
    n_cmp++;
    if (st !== want) begin
      n_bad++;
      $display("FAIL %s: got status=%b, want %b", nm, st, want);
    end
  endtask

  task automatic check_wr(input string nm, input int base, input int want);
    n_cmp++;
    if (n_wr - base !== want || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got writes=%0d pending=%0d, want %0d pending=0",
               nm, n_wr - base, exp_q.size(), want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_st("reset_status", 7'b0000100);
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata} !== 65'h0) begin
      n_bad++;
      $display("FAIL reset_imem: got we=%b addr=%h data=%h, want 0",
               imem_we, imem_addr, imem_wdata);
    end
  endtask

  task automatic test_load();
    int base;
    base = n_wr;
    build('{32'h00100513, 32'h00200593}, 8'h00);
    n_cmp++;
    if (stream[10] !== 8'hB0) begin
      n_bad++;
      $display("FAIL csum_model: got %h, want b0", stream[10]);
    end
    pulse_start();
    check_st("load_busy", 7'b1100100);
    foreach (stream[i]) send_byte(stream[i], 0);
    check_st("load_done", 7'b0010000);
    check_wr("load_writes", base, 2);
  endtask

  task automatic test_csum_err();
    int base;
    base = n_wr;
    build('{32'h00100513, 32'h00200593}, 8'h01);
    pulse_start();
    foreach (stream[i]) send_byte(stream[i], 0);
    check_st("csum_err", 7'b0001110);
    check_wr("csum_err_writes", base, 2);
  endtask

  task automatic test_oversize();
    int base;
    base = n_wr;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    repeat (3) @(negedge clk);
    check_st("oversize", 7'b0001101);
    check_wr("oversize_writes", base, 0);
  endtask

  task automatic test_gaps();
    int base;
    base = n_wr;
    build('{32'h00100513, 32'h00200593}, 8'h00);
    pulse_start();
    foreach (stream[i]) begin
      if (i == 6) begin
        rx_valid = 1'b0;
        pulse_start();
        check_st("start_ignored", 7'b1100100);
      end
      send_byte(stream[i], $urandom_range(0, 5));
    end
    check_st("gaps_done", 7'b0010000);
    check_wr("gaps_writes", base, 2);
  endtask

  task automatic test_reset_mid();
    int base;
    base = n_wr;
    build('{32'h00100513, 32'h00200593}, 8'h00);
    void'(exp_q.pop_back());
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    do_reset();
    check_st("mid_reset", 7'b0000100);
    repeat (4) @(negedge clk);
    check_wr("mid_reset_writes", base, 1);
    base = n_wr;
    build('{32'h00100513, 32'h00200593}, 8'h00);
    pulse_start();
    foreach (stream[i]) send_byte(stream[i], 0);
    check_st("post_reset_done", 7'b0010000);
    check_wr("post_reset_writes", base, 2);
  endtask

  task automatic test_empty();
    int base;
    base = n_wr;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_st("empty_csum_wait", 7'b1100100);
    send_byte(8'h00, 0);
    check_st("empty_done", 7'b0010000);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    check_st("empty_bad", 7'b0001110);
    check_wr("empty_writes", base, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load();
    test_csum_err();
    test_oversize();
    test_gaps();
    test_reset_mid();
    test_empty();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
